vga_pipe_ctrl: RTL and testbench

Parametrised VGA timing generator and pixel pipeline. It is the successor to the fixed 640x480 controller. Timing, sync polarity, colour depth and frame-memory read latency are all parameters. It emits a fetch address ahead of the beam and delay-matches sync/blank to the returned pixel, so memory latency no longer shifts the picture. It sits between the pixel-clock generator and the frame ROM/RAM, and drives the DAC pins directly.

---
 rtl/vga_pkg.sv | 36 +++
 rtl/vga_delay_line.sv | 37 +++
 rtl/vga_pipe_ctrl.sv | 133 +++++++++++++
 tb/tb_vga_pipe_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions: default 640x480@60 timing, the control bundle that
// travels through the latency-matching pipeline, and colour/sync helpers.
package vga_pkg;

    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FP      = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BP      = 48;
    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FP      = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BP      = 33;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic visible;
        logic frame_start;
        logic line_start;
    } vga_ctl_t;

    // Replicate a cbits-wide channel value MSB-first until 8 bits are filled.
    function automatic logic [7:0] expand_color(input logic [7:0] value, input int cbits);
        logic [7:0] res;
        res = '0;
        for (int i = 0; i < 8; i++) begin
            res[3'(7 - i)] = value[3'(cbits - 1 - (i % cbits))];
        end
        return res;
    endfunction

    function automatic logic in_window(input int cnt, input int lo, input int width);
        return (cnt >= lo) && (cnt < lo + width);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Parametrised shift register used to delay-match control signals to the
// frame-memory read latency; DEPTH=0 degenerates to a plain wire.
module vga_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (DEPTH == 0) begin : g_wire
        assign q_o = d_i;
    end else begin : g_shift
        logic [WIDTH-1:0] stage_q [DEPTH];

        // NOTE: every stage is reset, not just the last one, so that a reset
        // mid-frame cannot leak stale sync or pulse bits out after release.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= RESET_VAL;
                end
            end else begin
                stage_q[0] <= d_i;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_pipe_ctrl.sv
// Parametrised VGA timing generator: fetch address ahead of the beam, control
// signals delayed by LAT to meet the returned pixel, then one output register.
module vga_pipe_ctrl
    import vga_pkg::*;
#(
    parameter int H_VISIBLE   = VGA_H_VISIBLE,
    parameter int H_FP        = VGA_H_FP,
    parameter int H_SYNC      = VGA_H_SYNC,
    parameter int H_BP        = VGA_H_BP,
    parameter int V_VISIBLE   = VGA_V_VISIBLE,
    parameter int V_FP        = VGA_V_FP,
    parameter int V_SYNC      = VGA_V_SYNC,
    parameter int V_BP        = VGA_V_BP,
    parameter bit HS_POL      = 1'b0,
    parameter bit VS_POL      = 1'b0,
    parameter int CBITS       = 4,
    parameter int LAT         = 1,
    parameter int SCALE_SHIFT = 0
) (
    input  logic               pclk,
    input  logic               reset,
    input  logic [3*CBITS-1:0] pixel_data,
    output logic [9:0]         fetch_x,
    output logic [9:0]         fetch_y,
    output logic               fetch_valid,
    output logic               hsync,
    output logic               vsync,
    output logic               valid,
    output logic [7:0]         vga_r,
    output logic [7:0]         vga_g,
    output logic [7:0]         vga_b,
    output logic               frame_start,
    output logic               line_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam vga_ctl_t CTL_IDLE = '{hsync: !HS_POL, vsync: !VS_POL, default: 1'b0};

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_chk
        $error("vga_pipe_ctrl: line or frame total exceeds the 10-bit counters");
    end
    if (LAT < 0 || LAT > 7) begin : g_lat_chk
        $error("vga_pipe_ctrl: LAT must be 0..7");
    end
    if (CBITS < 1 || CBITS > 8) begin : g_cbits_chk
        $error("vga_pipe_ctrl: CBITS must be 1..8");
    end

    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic       visible;
    vga_ctl_t   ctl_raw, ctl_dly;

    // NOTE: defaults first in every always_comb so no path leaves a signal
    // unassigned and infers a latch.
    always_comb begin
        h_cnt_d = h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
        end
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign visible     = (int'(h_cnt_q) < H_VISIBLE) && (int'(v_cnt_q) < V_VISIBLE);
    assign fetch_valid = visible;
    assign fetch_x     = visible ? (h_cnt_q >> SCALE_SHIFT) : '0;
    assign fetch_y     = visible ? (v_cnt_q >> SCALE_SHIFT) : '0;

    always_comb begin
        ctl_raw.hsync       = in_window(int'(h_cnt_q), H_VISIBLE + H_FP, H_SYNC) ? HS_POL : !HS_POL;
        ctl_raw.vsync       = in_window(int'(v_cnt_q), V_VISIBLE + V_FP, V_SYNC) ? VS_POL : !VS_POL;
        ctl_raw.visible     = visible;
        ctl_raw.frame_start = (h_cnt_q == '0) && (v_cnt_q == '0);
        ctl_raw.line_start  = (h_cnt_q == '0) && visible;
    end

    vga_delay_line #(
        .WIDTH     ($bits(vga_ctl_t)),
        .DEPTH     (LAT),
        .RESET_VAL (CTL_IDLE)
    ) u_ctl_dly (
        .clk_i (pclk),
        .rst_i (reset),
        .d_i   (ctl_raw),
        .q_o   (ctl_dly)
    );

    logic [7:0] r_exp, g_exp, b_exp;
    assign r_exp = expand_color(8'(pixel_data[3*CBITS-1 -: CBITS]), CBITS);
    assign g_exp = expand_color(8'(pixel_data[2*CBITS-1 -: CBITS]), CBITS);
    assign b_exp = expand_color(8'(pixel_data[CBITS-1:0]), CBITS);

    vga_ctl_t   ctl_q;
    logic [7:0] vga_r_q, vga_g_q, vga_b_q;

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            ctl_q   <= CTL_IDLE;
            vga_r_q <= '0;
            vga_g_q <= '0;
            vga_b_q <= '0;
        end else begin
            ctl_q   <= ctl_dly;
            vga_r_q <= ctl_dly.visible ? r_exp : '0;
            vga_g_q <= ctl_dly.visible ? g_exp : '0;
            vga_b_q <= ctl_dly.visible ? b_exp : '0;
        end
    end

    assign hsync       = ctl_q.hsync;
    assign vsync       = ctl_q.vsync;
    assign valid       = ctl_q.visible;
    assign frame_start = ctl_q.frame_start;
    assign line_start  = ctl_q.line_start;
    assign vga_r       = vga_r_q;
    assign vga_g       = vga_g_q;
    assign vga_b       = vga_b_q;

endmodule

// File: tb/tb_vga_pipe_ctrl.sv
// Directed bench for vga_pipe_ctrl: several parameterisations run side by side
// off one clock and reset, checked against hand vectors and a cycle model.
module tb_vga_pipe_ctrl;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       valid;
        logic       fs;
        logic       ls;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } exp_t;

    typedef struct {
        int   cyc;
        exp_t e;
    } vec_t;

    localparam exp_t IDLE = {5'b11000, 24'h000000};

    logic pclk = 1'b0;
    logic reset = 1'b1;
    always #5 pclk = ~pclk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        @(negedge pclk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        reset = 1'b0;
        #1;
    endtask

    function automatic exp_t mk(input logic [4:0] flags, input logic [7:0] r,
                                input logic [7:0] g, input logic [7:0] b);
        return {flags, r, g, b};
    endfunction

    // Independent cycle model of the small-timing LAT=3 instance.
    function automatic exp_t model_main(input int n);
        exp_t e;
        int c, h, v;
        logic vis;
        logic [3:0] hn, vn;
        if (n < 4) return IDLE;
        c   = n - 4;
        h   = c % 14;
        v   = (c / 14) % 7;
        hn  = 4'(h);
        vn  = 4'(v);
        vis = (h < 8) && (v < 4);
        e.hs    = !(h >= 10 && h < 12);
        e.vs    = !(v == 5);
        e.valid = vis;
        e.fs    = (h == 0) && (v == 0);
        e.ls    = (h == 0) && (v < 4);
        e.r     = vis ? {hn, hn} : 8'h00;
        e.g     = vis ? {vn, vn} : 8'h00;
        e.b     = vis ? 8'hFF : 8'h00;
        return e;
    endfunction

    // ---- u_main: small timing, LAT=3, memory model returns {x,y,F}
    logic [9:0]  m_fx, m_fy;
    logic        m_fv, m_hs, m_vs, m_valid, m_fs, m_ls;
    logic [7:0]  m_r, m_g, m_b;
    logic [11:0] m_pix;
    logic [11:0] mem_q [3];
    exp_t        m_act;

    always @(posedge pclk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) mem_q[i] <= '0;
        end else begin
            mem_q[0] <= {m_fx[3:0], m_fy[3:0], 4'hF};
            mem_q[1] <= mem_q[0];
            mem_q[2] <= mem_q[1];
        end
    end
    assign m_pix = mem_q[2];
    assign m_act = {m_hs, m_vs, m_valid, m_fs, m_ls, m_r, m_g, m_b};

    vga_pipe_ctrl #(.H_VISIBLE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                    .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                    .CBITS(4), .LAT(3)) u_main (
        .pclk(pclk), .reset(reset), .pixel_data(m_pix),
        .fetch_x(m_fx), .fetch_y(m_fy), .fetch_valid(m_fv),
        .hsync(m_hs), .vsync(m_vs), .valid(m_valid),
        .vga_r(m_r), .vga_g(m_g), .vga_b(m_b),
        .frame_start(m_fs), .line_start(m_ls));

    // ---- u_col: constant pixel_data colour/blanking check
    logic [11:0] col_pix = 12'hA50;
    logic [9:0]  c_fx, c_fy;
    logic        c_fv, c_hs, c_vs, c_valid, c_fs, c_ls;
    logic [7:0]  c_r, c_g, c_b;

    vga_pipe_ctrl #(.H_VISIBLE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                    .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                    .CBITS(4), .LAT(1)) u_col (
        .pclk(pclk), .reset(reset), .pixel_data(col_pix),
        .fetch_x(c_fx), .fetch_y(c_fy), .fetch_valid(c_fv),
        .hsync(c_hs), .vsync(c_vs), .valid(c_valid),
        .vga_r(c_r), .vga_g(c_g), .vga_b(c_b),
        .frame_start(c_fs), .line_start(c_ls));

    // ---- u_cb3: 3-bit channels
    logic [8:0] cb3_pix = 9'b101_011_110;
    logic [9:0] t_fx, t_fy;
    logic       t_fv, t_hs, t_vs, t_valid, t_fs, t_ls;
    logic [7:0] t_r, t_g, t_b;

    vga_pipe_ctrl #(.H_VISIBLE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                    .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                    .CBITS(3), .LAT(1)) u_cb3 (
        .pclk(pclk), .reset(reset), .pixel_data(cb3_pix),
        .fetch_x(t_fx), .fetch_y(t_fy), .fetch_valid(t_fv),
        .hsync(t_hs), .vsync(t_vs), .valid(t_valid),
        .vga_r(t_r), .vga_g(t_g), .vga_b(t_b),
        .frame_start(t_fs), .line_start(t_ls));

    // ---- u_scl: SCALE_SHIFT=1
    logic [11:0] zero_pix = 12'h000;
    logic [9:0]  s_fx, s_fy;
    logic        s_fv, s_hs, s_vs, s_valid, s_fs, s_ls;
    logic [7:0]  s_r, s_g, s_b;

    vga_pipe_ctrl #(.H_VISIBLE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                    .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                    .SCALE_SHIFT(1)) u_scl (
        .pclk(pclk), .reset(reset), .pixel_data(zero_pix),
        .fetch_x(s_fx), .fetch_y(s_fy), .fetch_valid(s_fv),
        .hsync(s_hs), .vsync(s_vs), .valid(s_valid),
        .vga_r(s_r), .vga_g(s_g), .vga_b(s_b),
        .frame_start(s_fs), .line_start(s_ls));

    // ---- u_pol: active-high syncs
    logic [9:0] p_fx, p_fy;
    logic       p_fv, p_hs, p_vs, p_valid, p_fs, p_ls;
    logic [7:0] p_r, p_g, p_b;

    vga_pipe_ctrl #(.H_VISIBLE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                    .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                    .HS_POL(1'b1), .VS_POL(1'b1)) u_pol (
        .pclk(pclk), .reset(reset), .pixel_data(zero_pix),
        .fetch_x(p_fx), .fetch_y(p_fy), .fetch_valid(p_fv),
        .hsync(p_hs), .vsync(p_vs), .valid(p_valid),
        .vga_r(p_r), .vga_g(p_g), .vga_b(p_b),
        .frame_start(p_fs), .line_start(p_ls));

    // ---- u_def: default 640x480 timing
    logic [11:0] def_pix = 12'h123;
    logic [9:0]  d_fx, d_fy;
    logic        d_fv, d_hs, d_vs, d_valid, d_fs, d_ls;
    logic [7:0]  d_r, d_g, d_b;

    vga_pipe_ctrl u_def (
        .pclk(pclk), .reset(reset), .pixel_data(def_pix),
        .fetch_x(d_fx), .fetch_y(d_fy), .fetch_valid(d_fv),
        .hsync(d_hs), .vsync(d_vs), .valid(d_valid),
        .vga_r(d_r), .vga_g(d_g), .vga_b(d_b),
        .frame_start(d_fs), .line_start(d_ls));

    vec_t vec [18];

    initial begin
        int ti, sweep_err, sweep_first, m_vcnt, vf1, vf2, vr1;
        int hf1, hf2, hr1, d_vcnt, fs_at;
        logic prev;

        vec[0]  = '{cyc: 0,   e: mk(5'b11000, 8'h00, 8'h00, 8'h00)};
        vec[1]  = '{cyc: 3,   e: mk(5'b11000, 8'h00, 8'h00, 8'h00)};
        vec[2]  = '{cyc: 4,   e: mk(5'b11111, 8'h00, 8'h00, 8'hFF)};
        vec[3]  = '{cyc: 5,   e: mk(5'b11100, 8'h11, 8'h00, 8'hFF)};
        vec[4]  = '{cyc: 11,  e: mk(5'b11100, 8'h77, 8'h00, 8'hFF)};
        vec[5]  = '{cyc: 12,  e: mk(5'b11000, 8'h00, 8'h00, 8'h00)};
        vec[6]  = '{cyc: 14,  e: mk(5'b01000, 8'h00, 8'h00, 8'h00)};
        vec[7]  = '{cyc: 15,  e: mk(5'b01000, 8'h00, 8'h00, 8'h00)};
        vec[8]  = '{cyc: 16,  e: mk(5'b11000, 8'h00, 8'h00, 8'h00)};
        vec[9]  = '{cyc: 18,  e: mk(5'b11101, 8'h00, 8'h11, 8'hFF)};
        vec[10] = '{cyc: 37,  e: mk(5'b11100, 8'h55, 8'h22, 8'hFF)};
        vec[11] = '{cyc: 60,  e: mk(5'b11000, 8'h00, 8'h00, 8'h00)};
        vec[12] = '{cyc: 77,  e: mk(5'b10000, 8'h00, 8'h00, 8'h00)};
        vec[13] = '{cyc: 85,  e: mk(5'b00000, 8'h00, 8'h00, 8'h00)};
        vec[14] = '{cyc: 88,  e: mk(5'b11000, 8'h00, 8'h00, 8'h00)};
        vec[15] = '{cyc: 101, e: mk(5'b11000, 8'h00, 8'h00, 8'h00)};
        vec[16] = '{cyc: 102, e: mk(5'b11111, 8'h00, 8'h00, 8'hFF)};
        vec[17] = '{cyc: 150, e: mk(5'b11100, 8'h66, 8'h33, 8'hFF)};

        // Reset state while reset is held.
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        check("rst_main_outputs", 32'(m_act), 32'(IDLE));
        check("rst_pol_syncs", 32'({p_hs, p_vs}), 32'h0);
        check("rst_def_outputs", 32'({d_hs, d_vs, d_valid, d_fs, d_ls}), 32'h18);

        // Main sweep: hand vectors, cycle model and side checks on the small instances.
        do_reset();
        ti = 0; sweep_err = 0; sweep_first = -1; m_vcnt = 0;
        vf1 = -1; vf2 = -1; vr1 = -1; prev = 1'b1;
        for (int n = 0; n <= 200; n++) begin
            if (n > 0) step();
            while (ti < 18 && vec[ti].cyc == n) begin
                check($sformatf("vec_cyc%0d", n), 32'(m_act), 32'(vec[ti].e));
                ti++;
            end
            if (m_act !== model_main(n)) begin
                sweep_err++;
                if (sweep_first < 0) sweep_first = n;
            end
            if (n >= 4 && n < 102 && m_valid) m_vcnt++;
            if (prev && !m_vs) begin
                if (vf1 < 0) vf1 = n; else if (vf2 < 0) vf2 = n;
            end
            if (!prev && m_vs && vr1 < 0) vr1 = n;
            prev = m_vs;

            if (n == 2)  check("col_a50_visible", 32'({c_r, c_g, c_b}), 32'hAA5500);
            if (n == 12) check("col_a50_blank", 32'({c_r, c_g, c_b}), 32'h0);
            if (n == 40) col_pix = 12'hFFF;
            if (n == 46) check("col_fff_visible", 32'({c_r, c_g, c_b}), 32'hFFFFFF);
            if (n == 52) check("col_fff_hblank", 32'({c_r, c_g, c_b}), 32'h0);
            if (n == 60) check("col_fff_vblank", 32'({c_r, c_g, c_b}), 32'h0);
            if (n == 2)  check("cbits3_expand", 32'({t_r, t_g, t_b}), 32'hB66DDB);

            if (n < 8)   check($sformatf("scale_fx_h%0d", n), 32'({s_fv, s_fx}), 32'(1024 + (n >> 1)));
            if (n == 8)  check("scale_fx_blank", 32'({s_fv, s_fx}), 32'h0);
            if (n < 70 && n % 14 == 3)
                check($sformatf("scale_fy_v%0d", n / 14), 32'(s_fy), 32'(n < 56 ? (n / 14) >> 1 : 0));

            if (n == 0)  check("pol_idle", 32'({p_hs, p_vs}), 32'h0);
            if (n == 12) check("pol_hs_active", 32'(p_hs), 32'h1);
            if (n == 14) check("pol_hs_end", 32'(p_hs), 32'h0);
            if (n == 72) check("pol_vs_active", 32'(p_vs), 32'h1);
            if (n == 86) check("pol_vs_end", 32'(p_vs), 32'h0);
        end
        if (sweep_err != 0) $display("note: first model divergence at cycle %0d", sweep_first);
        check("model_sweep_errors", 32'(sweep_err), 32'h0);
        check("small_valid_per_frame", 32'(m_vcnt), 32'd32);
        check("small_vsync_period", 32'(vf2 - vf1), 32'd98);
        check("small_vsync_width", 32'(vr1 - vf1), 32'd14);

        // Default 640x480 timing over two lines.
        do_reset();
        hf1 = -1; hf2 = -1; hr1 = -1; d_vcnt = 0; prev = 1'b1;
        for (int n = 0; n <= 1700; n++) begin
            if (n > 0) step();
            if (n < 800 && d_valid) d_vcnt++;
            if (prev && !d_hs) begin
                if (hf1 < 0) hf1 = n; else if (hf2 < 0) hf2 = n;
            end
            if (!prev && d_hs && hr1 < 0) hr1 = n;
            prev = d_hs;
        end
        check("def_hsync_first_fall", 32'(hf1), 32'd658);
        check("def_hsync_period", 32'(hf2 - hf1), 32'd800);
        check("def_hsync_width", 32'(hr1 - hf1), 32'd96);
        check("def_valid_per_line", 32'(d_vcnt), 32'd640);
        check("def_vsync_idle", 32'(d_vs), 32'h1);

        // Asynchronous reset at h=5, v=2, then restart latency.
        do_reset();
        repeat (33) step();
        check("midrst_fetch_pos", 32'({m_fx, m_fy}), 32'({10'd5, 10'd2}));
        check("midrst_pre_valid", 32'(m_valid), 32'h1);
        #2 reset = 1'b1;
        #1;
        check("midrst_outputs_async", 32'(m_act), 32'(IDLE));
        check("midrst_fetch_zero", 32'({m_fx, m_fy}), 32'h0);
        @(posedge pclk);
        @(negedge pclk);
        reset = 1'b0;
        #1;
        fs_at = -1;
        if (m_fs) fs_at = 0;
        for (int k = 1; k <= 50 && fs_at < 0; k++) begin
            step();
            if (m_fs) fs_at = k;
        end
        check("midrst_frame_start_latency", 32'(fs_at), 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
